audio_stream_core: RTL and testbench

AUDIO_STREAM_CORE -- requirements
Module: audio_stream_core

---
 rtl/audio_stream_core.sv | 134 +++++++++++++
 tb/tb_audio_stream_core.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/audio_stream_core.sv
// audio_stream_core: frame-based codec effects pipeline (mute, clip, echo); echo RAM enabled by AUDIO_STREAM_CORE_ECHO_EN
module audio_stream_core #(
  parameter int W           = 32,
  parameter int NUM_CH      = 2,
  parameter int DELAY_DEPTH = 4096,
  parameter int ECHO_SHIFT  = 1
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                mute_en,
  input  logic                dist_en,
  input  logic                echo_en,
  input  logic [W-2:0]        dist_thresh,
  input  logic                audio_in_available,
  input  logic                audio_out_allowed,
  output logic                read_audio_in,
  output logic                write_audio_out,
  input  logic [NUM_CH*W-1:0] audio_in,
  output logic [NUM_CH*W-1:0] audio_out,
  output logic                busy
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  typedef enum logic [1:0] {IDLE, PROC, WRITE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_ch;
  logic [NUM_CH*W-1:0] r_in, r_res, r_out, w_frame;
  logic r_mute, r_dist, r_read, r_write;
  logic [W-2:0] r_thresh;
  logic w_accept, w_last;
  logic signed [W-1:0] w_x, w_m, w_d, w_y, w_pos, w_neg;
  assign w_accept = r_state == IDLE && audio_in_available && audio_out_allowed;
  assign w_last = r_state == PROC && r_ch == LAST;
  assign read_audio_in = r_read;
  assign write_audio_out = r_write;
  assign audio_out = r_out;
  assign busy = r_state != IDLE;
  // state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state: accept, one cycle per channel, then wait for the codec to take the frame
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = PROC;
      PROC:    if (r_ch == LAST) w_next = WRITE;
      WRITE:   if (audio_out_allowed) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // mute then symmetric clip against the frame-latched threshold
  assign w_x = r_in[int'(r_ch)*W +: W];
  assign w_m = r_mute ? '0 : w_x;
  assign w_pos = $signed({1'b0, r_thresh});
  assign w_neg = -w_pos;
  assign w_d = !r_dist ? w_m : (w_m > w_pos) ? w_pos : (w_m < w_neg) ? w_neg : w_m;
`ifdef AUDIO_STREAM_CORE_ECHO_EN
  localparam int PW = DELAY_DEPTH > 1 ? $clog2(DELAY_DEPTH) : 1;
  localparam int AW = $clog2(DELAY_DEPTH * NUM_CH);
  logic [W-1:0] r_mem [DELAY_DEPTH*NUM_CH];
  logic [PW-1:0] r_ptr;
  logic [PW:0] r_fill;
  logic r_echo;
  logic [AW-1:0] w_addr;
  logic signed [W-1:0] w_tap, w_sh;
  logic signed [W:0] w_sum;
  assign w_addr = AW'(int'(r_ptr) * NUM_CH + int'(r_ch));
  assign w_tap = r_fill == (PW+1)'(DELAY_DEPTH) ? $signed(r_mem[w_addr]) : '0;
  assign w_sh = w_tap >>> ECHO_SHIFT;
  assign w_sum = {w_d[W-1], w_d} + {w_sh[W-1], w_sh};
  assign w_y = !r_echo ? w_d :
               (w_sum[W] != w_sum[W-1]) ? (w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) :
               w_sum[W-1:0];
  // delay line: read-before-write, so the tap is the sample stored DELAY_DEPTH frames ago
  always_ff @(posedge CLOCK_50) begin
    if (r_state == PROC) r_mem[w_addr] <= w_d;
  end
  // frame pointer and fill level advance after the last channel of each frame
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
      r_fill <= '0;
      r_echo <= 1'b0;
    end else begin
      if (w_accept) r_echo <= echo_en;
      if (w_last) begin
        r_ptr <= r_ptr == PW'(DELAY_DEPTH - 1) ? '0 : r_ptr + PW'(1);
        r_fill <= r_fill == (PW+1)'(DELAY_DEPTH) ? r_fill : r_fill + (PW+1)'(1);
      end
    end
  end
`else
  localparam int unused_cfg = DELAY_DEPTH + ECHO_SHIFT;
  logic w_unused;
  assign w_unused = echo_en;
  assign w_y = w_d;
`endif
  // merge the final channel into the collected results so the output frame loads in one edge
  always_comb begin
    w_frame = r_res;
    w_frame[int'(r_ch)*W +: W] = w_y;
  end
  // frame capture, channel sequencing, result collection and codec strobes
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_ch <= '0;
      r_in <= '0;
      r_res <= '0;
      r_out <= '0;
      r_mute <= 1'b0;
      r_dist <= 1'b0;
      r_thresh <= '0;
      r_read <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_read <= w_accept;
      r_write <= r_state == WRITE && audio_out_allowed;
      if (w_accept) begin
        r_ch <= '0;
        r_in <= audio_in;
        r_mute <= mute_en;
        r_dist <= dist_en;
        r_thresh <= dist_thresh;
      end
      if (r_state == PROC) begin
        r_ch <= w_last ? '0 : r_ch + CW'(1);
        r_res <= w_frame;
      end
      if (w_last) r_out <= w_frame;
    end
  end
endmodule

// File: tb/tb_audio_stream_core.sv
// tb_audio_stream_core: directed frames with hand-computed results for audio_stream_core
module tb_audio_stream_core;
  localparam int W = 32;
`ifdef AUDIO_STREAM_CORE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  logic clk = 0, resetn = 0, mute_en = 0, dist_en = 0, echo_en = 0;
  logic [W-2:0] dist_thresh = '0;
  logic avail = 0, allowed = 0, rd, wr, busy;
  logic [2*W-1:0] din = '0, dout;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  audio_stream_core #(.W(W), .NUM_CH(2), .DELAY_DEPTH(4), .ECHO_SHIFT(1)) dut (
    .CLOCK_50(clk), .resetn(resetn), .mute_en(mute_en), .dist_en(dist_en), .echo_en(echo_en),
    .dist_thresh(dist_thresh), .audio_in_available(avail), .audio_out_allowed(allowed),
    .read_audio_in(rd), .write_audio_out(wr), .audio_in(din), .audio_out(dout), .busy(busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rst_pulse();
    @(negedge clk);
    avail = 0;
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask
  task automatic frame(input logic [31:0] l, input logic [31:0] r, input logic m, input logic d,
                       input logic e, input logic [30:0] t, input logic [31:0] el,
                       input logic [31:0] er, input string tag);
    int k;
    bit seen;
    @(negedge clk);
    din = {r, l};
    mute_en = m;
    dist_en = d;
    echo_en = e;
    dist_thresh = t;
    avail = 1;
    allowed = 1;
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = rd;
    end
    chk({tag, "_rd"}, 32'(seen), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
    avail = 0;
    mute_en = ~m;
    dist_en = ~d;
    echo_en = ~e;
    dist_thresh = ~t;
    din = ~din;
    seen = 0;
    k = 0;
    while (k < 10 && !seen) begin
      @(negedge clk);
      k++;
      seen = wr;
    end
    chk({tag, "_lat"}, 32'(k), 3);
    chk({tag, "_rd_at_wr"}, 32'(rd), 0);
    chk({tag, "_l"}, dout[31:0], el);
    chk({tag, "_r"}, dout[63:32], er);
    @(negedge clk);
    chk({tag, "_wr_once"}, 32'(wr), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    int k;
    bit seen;
    resetn = 0;
    avail = 1;
    allowed = 1;
    din = {32'h1234_5678, 32'h9abc_def0};
    repeat (3) @(negedge clk);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_l", dout[31:0], 0);
    chk("rst_out_r", dout[63:32], 0);
    avail = 0;
    @(negedge clk);
    resetn = 1;
    frame(1000, -2000, 0, 0, 0, 0, 1000, -2000, "pass");
    frame(12000, -9000, 0, 1, 0, 5000, 5000, -5000, "dist");
    frame(12000, -9000, 1, 1, 0, 5000, 0, 0, "mute");
    frame(5000, -5001, 0, 1, 0, 5000, 5000, -5000, "dist_edge");
    rst_pulse();
    for (int i = 0; i < 6; i++)
      frame(i == 0 ? 1000 : 0, i == 0 ? -3000 : 0, 0, 0, 1, 0,
            (i == 0) ? 1000 : (i == 4 && ECHO) ? 500 : 0,
            (i == 0) ? -3000 : (i == 4 && ECHO) ? -1500 : 0, "echo");
    rst_pulse();
    for (int i = 0; i < 5; i++)
      frame((i == 0 || i == 4) ? 32'h7FFF_FFF0 : 0, (i == 0 || i == 4) ? 32'h8000_0010 : 0, 0, 0, 1, 0,
            (i == 0) ? 32'h7FFF_FFF0 : (i == 4) ? (ECHO ? 32'h7FFF_FFFF : 32'h7FFF_FFF0) : 0,
            (i == 0) ? 32'h8000_0010 : (i == 4) ? (ECHO ? 32'h8000_0000 : 32'h8000_0010) : 0, "sat");
    @(negedge clk);
    din = {32'hFFFF_FFF9, 32'd77};
    mute_en = 0;
    dist_en = 0;
    echo_en = 0;
    avail = 1;
    allowed = 1;
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = rd;
    end
    chk("bp_rd", 32'(seen), 1);
    avail = 0;
    allowed = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_no_wr", 32'(wr), 0);
    end
    chk("bp_busy", 32'(busy), 1);
    chk("bp_hold_l", dout[31:0], 77);
    chk("bp_hold_r", dout[63:32], -7);
    allowed = 1;
    seen = 0;
    k = 0;
    while (k < 10 && !seen) begin
      @(negedge clk);
      k++;
      seen = wr;
    end
    chk("bp_lat", 32'(k), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_once", 32'(wr), 0);
    end
    @(negedge clk);
    din = {32'd55, 32'd66};
    avail = 1;
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = rd;
    end
    chk("mid_rd", 32'(seen), 1);
    avail = 0;
    resetn = 0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rd0", 32'(rd), 0);
    chk("mid_out_l", dout[31:0], 0);
    chk("mid_out_r", dout[63:32], 0);
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_wr", 32'(wr), 0);
    end
    chk("mid_out_final", dout[31:0], 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
